// File: rtl/multi_random_state_generator_pkg.sv
// random_state_pkg: shared constants and pure helper functions for the random
// two-level waveform generator.
//   lfsr_step : one step of the 32-bit Galois LFSR
//   chseed    : per-channel seed derived from a base seed, never zero
//   draw      : hold length in [min_val, max_val] from the current LFSR value
package random_state_pkg;

  localparam int unsigned LFSR_WIDTH = 32;
  localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [LFSR_WIDTH-1:0] SEED_STEP = 32'h9E37_79B9;

  // UNPRIMED doubles as "primed=0"; LOW/HIGH carry the output level.
  typedef enum logic [1:0] {
    PH_UNPRIMED = 2'd0,
    PH_LOW      = 2'd1,
    PH_HIGH     = 2'd2
  } ch_phase_e;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [LFSR_WIDTH-1:0] chseed(input logic [LFSR_WIDTH-1:0] s,
                                                   input int unsigned ch);
    logic [LFSR_WIDTH-1:0] v;
    v = s ^ (ch * SEED_STEP);
    // An all-zero Galois LFSR never leaves zero.
    return (v == '0) ? 32'd1 : v;
  endfunction

  // Take the low clog2(range) LFSR bits; one conditional subtract folds the
  // overshoot back into range since those bits are always < 2*range.
  function automatic logic [31:0] draw(input logic [LFSR_WIDTH-1:0] lfsr,
                                       input int unsigned min_val,
                                       input int unsigned max_val);
    logic [31:0] range;
    logic [31:0] mask;
    logic [31:0] r;
    int unsigned rw;
    range = max_val - min_val + 32'd1;
    rw    = $clog2(range);
    mask  = (rw >= 32) ? '1 : ((32'd1 << rw) - 32'd1);
    r     = lfsr & mask;
    if (r >= range) r = r - range;
    return min_val + r;
  endfunction

endpackage

// File: rtl/multi_random_state_generator_if.sv
// Control/observation bundle of the multi-channel random state generator.
//   i_en        channels advance when 1
//   i_seed_load 1-cycle strobe: reseed and restart all channels
//   i_seed      base seed for i_seed_load
//   o_state     per-channel level
//   o_toggle    per-channel 1-cycle pulse when o_state changes
interface multi_random_state_generator_if
  import random_state_pkg::*;
#(
  parameter int unsigned CH_NUM = 4
) ();

  logic                  i_en;
  logic                  i_seed_load;
  logic [LFSR_WIDTH-1:0] i_seed;
  logic [CH_NUM-1:0]     o_state;
  logic [CH_NUM-1:0]     o_toggle;

  modport master (output i_en, i_seed_load, i_seed, input o_state, o_toggle);
  modport slave  (input i_en, i_seed_load, i_seed, output o_state, o_toggle);

endinterface

// File: rtl/multi_random_state_generator_channel.sv
// random_state_channel: one channel = LFSR + hold down-counter + level + toggle.
//   i_clk, i_a_rst_n   clock, async active-low reset
//   i_en               advance this cycle
//   i_seed_load        reseed from chseed(i_seed, CH_IDX) and restart
//   o_state, o_toggle  level and its change strobe
//
//   phase       | meaning
//   PH_UNPRIMED | after reset/reseed; next enabled edge loads first level-0 hold
//   PH_LOW      | output 0, counting down the current hold
//   PH_HIGH     | output 1, counting down the current hold
module random_state_channel
  import random_state_pkg::*;
#(
  parameter int unsigned           CNT_WIDTH = 16,
  parameter int unsigned           S0_MIN    = 100,
  parameter int unsigned           S0_MAX    = 600,
  parameter int unsigned           S1_MIN    = 60,
  parameter int unsigned           S1_MAX    = 500,
  parameter int unsigned           CH_IDX    = 0,
  parameter logic [LFSR_WIDTH-1:0] CH_SEED   = 32'h1
) (
  input  logic                  i_clk,
  input  logic                  i_a_rst_n,
  input  logic                  i_en,
  input  logic                  i_seed_load,
  input  logic [LFSR_WIDTH-1:0] i_seed,
  output logic                  o_state,
  output logic                  o_toggle
);

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  ch_phase_e             phase_q, phase_d;
  logic                  toggle_q, toggle_d;
  logic [31:0]           hold0, hold1;

  always_comb begin
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    toggle_d = 1'b0;
    // Both draws use the LFSR value from before this cycle's step.
    hold0    = draw(lfsr_q, S0_MIN, S0_MAX);
    hold1    = draw(lfsr_q, S1_MIN, S1_MAX);
    if (i_seed_load) begin
      lfsr_d  = chseed(i_seed, CH_IDX);
      cnt_d   = '0;
      phase_d = PH_UNPRIMED;
    end else if (i_en) begin
      lfsr_d = lfsr_step(lfsr_q);
      case (phase_q)
        PH_UNPRIMED: begin
          cnt_d   = CNT_WIDTH'(hold0 - 32'd1);
          phase_d = PH_LOW;
        end
        PH_LOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end else begin
            phase_d  = PH_HIGH;
            toggle_d = 1'b1;
            cnt_d    = CNT_WIDTH'(hold1 - 32'd1);
          end
        end
        PH_HIGH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end else begin
            phase_d  = PH_LOW;
            toggle_d = 1'b1;
            cnt_d    = CNT_WIDTH'(hold0 - 32'd1);
          end
        end
        default: phase_d = PH_UNPRIMED;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      lfsr_q   <= CH_SEED;
      cnt_q    <= '0;
      phase_q  <= PH_UNPRIMED;
      toggle_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      toggle_q <= toggle_d;
    end
  end

  assign o_state  = (phase_q == PH_HIGH);
  assign o_toggle = toggle_q;

endmodule

// File: rtl/multi_random_state_generator.sv
// multi_random_state_generator: CH_NUM independent random two-level waveforms.
//   i_clk, i_a_rst_n  clock, async active-low reset
//   bus (slave)       i_en / i_seed_load / i_seed in, o_state / o_toggle out
module multi_random_state_generator
  import random_state_pkg::*;
#(
  parameter int unsigned           CH_NUM          = 4,
  parameter int unsigned           CNT_WIDTH       = 16,
  parameter int unsigned           STATE_0_MIN_VAL = 100,
  parameter int unsigned           STATE_0_MAX_VAL = 600,
  parameter int unsigned           STATE_1_MIN_VAL = 60,
  parameter int unsigned           STATE_1_MAX_VAL = 500,
  parameter logic [LFSR_WIDTH-1:0] SEED            = 32'hACE1_2468
) (
  input  logic                           i_clk,
  input  logic                           i_a_rst_n,
  multi_random_state_generator_if.slave  bus
);

  if (CH_NUM < 1 ||
      STATE_0_MIN_VAL < 1 || STATE_0_MAX_VAL < STATE_0_MIN_VAL ||
      STATE_1_MIN_VAL < 1 || STATE_1_MAX_VAL < STATE_1_MIN_VAL ||
      64'(STATE_0_MAX_VAL) >= (64'd1 << CNT_WIDTH) ||
      64'(STATE_1_MAX_VAL) >= (64'd1 << CNT_WIDTH)) begin : g_bad_params
    $error("multi_random_state_generator: illegal hold/counter parameters");
  end

  logic [CH_NUM-1:0] state_w;
  logic [CH_NUM-1:0] toggle_w;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    random_state_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .S0_MIN    (STATE_0_MIN_VAL),
      .S0_MAX    (STATE_0_MAX_VAL),
      .S1_MIN    (STATE_1_MIN_VAL),
      .S1_MAX    (STATE_1_MAX_VAL),
      .CH_IDX    (g),
      .CH_SEED   (chseed(SEED, g))
    ) u_ch (
      .i_clk       (i_clk),
      .i_a_rst_n   (i_a_rst_n),
      .i_en        (bus.i_en),
      .i_seed_load (bus.i_seed_load),
      .i_seed      (bus.i_seed),
      .o_state     (state_w[g]),
      .o_toggle    (toggle_w[g])
    );
  end

  assign bus.o_state  = state_w;
  assign bus.o_toggle = toggle_w;

endmodule

// File: tb/tb_multi_random_state_generator.sv
module tb_multi_random_state_generator;

  localparam int CH     = 4;
  localparam int S0_MIN = 100;
  localparam int S0_MAX = 600;
  localparam int S1_MIN = 60;
  localparam int S1_MAX = 500;
  localparam logic [31:0] BASE_SEED = 32'hACE1_2468;
  localparam int NTR = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_random_state_generator_if #(.CH_NUM(CH)) bus ();
  multi_random_state_generator_if #(.CH_NUM(1))  bus_f ();

  multi_random_state_generator #(
    .CH_NUM(CH), .CNT_WIDTH(16),
    .STATE_0_MIN_VAL(S0_MIN), .STATE_0_MAX_VAL(S0_MAX),
    .STATE_1_MIN_VAL(S1_MIN), .STATE_1_MAX_VAL(S1_MAX),
    .SEED(BASE_SEED)
  ) dut (.i_clk(clk), .i_a_rst_n(rst_n), .bus(bus));

  multi_random_state_generator #(
    .CH_NUM(1), .CNT_WIDTH(16),
    .STATE_0_MIN_VAL(5), .STATE_0_MAX_VAL(5),
    .STATE_1_MIN_VAL(5), .STATE_1_MAX_VAL(5),
    .SEED(BASE_SEED)
  ) dut_f (.i_clk(clk), .i_a_rst_n(rst_n), .bus(bus_f));

  int checks = 0;
  int errors = 0;

  // Reference model, written independently of the design package.
  logic [31:0]   m_lfsr[CH];
  int            m_cnt[CH];
  bit            m_primed[CH];
  logic [CH-1:0] m_st, m_tg;

  typedef struct packed {
    logic [CH-1:0] st;
    logic [CH-1:0] tg;
  } obs_t;
  obs_t sb_q[$];

  int hold_len[CH];
  bit hold_seen[CH];

  function automatic logic [31:0] m_step(logic [31:0] s);
    logic fb;
    fb = s[0];
    s  = {1'b0, s[31:1]};
    if (fb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  function automatic logic [31:0] m_seed(logic [31:0] s, int ch);
    logic [31:0] v;
    v = s ^ 32'(64'(ch) * 64'h9E37_79B9);
    if (v == 32'd0) v = 32'd1;
    return v;
  endfunction

  function automatic int m_hold(logic [31:0] l, int lo, int hi);
    int rng;
    int rw;
    logic [31:0] r;
    rng = hi - lo + 1;
    rw  = 0;
    while ((64'd1 << rw) < 64'(rng)) rw++;
    r = l & ((32'd1 << rw) - 32'd1);
    return lo + int'(r % 32'(rng));
  endfunction

  function automatic void m_reset(logic [31:0] seed);
    for (int c = 0; c < CH; c++) begin
      m_lfsr[c]   = m_seed(seed, c);
      m_cnt[c]    = 0;
      m_primed[c] = 1'b0;
    end
    m_st = '0;
    m_tg = '0;
  endfunction

  function automatic void trk_clear();
    for (int c = 0; c < CH; c++) begin
      hold_len[c]  = 0;
      hold_seen[c] = 1'b0;
    end
  endfunction

  function automatic void m_advance(logic en, logic sl, logic [31:0] seed);
    if (sl) begin
      m_reset(seed);
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_tg[c] = 1'b0;
        if (en) begin
          if (!m_primed[c]) begin
            m_cnt[c]    = m_hold(m_lfsr[c], S0_MIN, S0_MAX) - 1;
            m_primed[c] = 1'b1;
          end else if (m_cnt[c] != 0) begin
            m_cnt[c]--;
          end else begin
            m_st[c]  = ~m_st[c];
            m_tg[c]  = 1'b1;
            m_cnt[c] = m_st[c] ? m_hold(m_lfsr[c], S1_MIN, S1_MAX) - 1
                               : m_hold(m_lfsr[c], S0_MIN, S0_MAX) - 1;
          end
          m_lfsr[c] = m_step(m_lfsr[c]);
        end
      end
    end
  endfunction

  // One clock: push the expectation for the inputs now driven, then at the
  // next falling edge pop it and compare, and check completed hold lengths.
  task automatic tick();
    obs_t e;
    logic en_e, sl_e;
    int lo, hi;
    en_e = bus.i_en;
    sl_e = bus.i_seed_load;
    m_advance(en_e, sl_e, bus.i_seed);
    sb_q.push_back({m_st, m_tg});
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (bus.o_state !== e.st || bus.o_toggle !== e.tg) begin
      errors++;
      $display("FAIL model_trace t=%0t got state=%b toggle=%b want state=%b toggle=%b",
               $time, bus.o_state, bus.o_toggle, e.st, e.tg);
    end
    if (sl_e) begin
      trk_clear();
    end else if (en_e) begin
      for (int c = 0; c < CH; c++) begin
        hold_len[c]++;
        if (bus.o_toggle[c]) begin
          if (hold_seen[c]) begin
            lo = bus.o_state[c] ? S0_MIN : S1_MIN;
            hi = bus.o_state[c] ? S0_MAX : S1_MAX;
            checks++;
            if (hold_len[c] < lo || hold_len[c] > hi) begin
              errors++;
              $display("FAIL hold_bounds ch%0d got %0d want [%0d,%0d]", c, hold_len[c], lo, hi);
            end
          end
          hold_seen[c] = 1'b1;
          hold_len[c]  = 0;
        end
      end
    end
  endtask

  task automatic chk_zero(string name);
    checks++;
    if (bus.o_state !== '0 || bus.o_toggle !== '0 || bus_f.o_state !== 1'b0 || bus_f.o_toggle !== 1'b0) begin
      errors++;
      $display("FAIL %s got state=%b toggle=%b fstate=%b ftoggle=%b want all zero",
               name, bus.o_state, bus.o_toggle, bus_f.o_state, bus_f.o_toggle);
    end
  endtask

  // Fixed-period vectors for dut_f (all holds = 5): {en, seed_load, exp_state, exp_toggle}
  typedef struct packed {
    logic en;
    logic sl;
    logic st;
    logic tg;
  } vec_t;
  vec_t tbl[30];

  logic [CH-1:0] tr_a[NTR];
  logic [CH-1:0] tr_b[NTR];
  int diff;
  int tog0;

  initial begin
    tbl = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
            4'b1011,
            4'b1010, 4'b1010, 4'b1010, 4'b1010,
            4'b1001,
            4'b1000, 4'b1000,
            4'b0000, 4'b0000, 4'b0000,
            4'b1000, 4'b1000,
            4'b1011,
            4'b0010,
            4'b1010,
            4'b1100,
            4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
            4'b1011,
            4'b0100,
            4'b1000};

    bus.i_en = 1'b0;   bus.i_seed_load = 1'b0;   bus.i_seed = '0;
    bus_f.i_en = 1'b0; bus_f.i_seed_load = 1'b0; bus_f.i_seed = '0;
    m_reset(BASE_SEED);
    trk_clear();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_zero("reset_state");

    // Fixed period, gating and reseed on the single-channel instance.
    for (int i = 0; i < 30; i++) begin
      bus_f.i_en        = tbl[i].en;
      bus_f.i_seed_load = tbl[i].sl;
      tick();
      checks++;
      if (bus_f.o_state !== tbl[i].st || bus_f.o_toggle !== tbl[i].tg) begin
        errors++;
        $display("FAIL fixed_vec[%0d] got state=%b toggle=%b want state=%b toggle=%b",
                 i, bus_f.o_state, bus_f.o_toggle, tbl[i].st, tbl[i].tg);
      end
    end
    bus_f.i_en = 1'b0;
    bus_f.i_seed_load = 1'b0;

    // Power-on trace of the default instance.
    bus.i_en = 1'b1;
    for (int t = 0; t < NTR; t++) begin
      tick();
      tr_a[t] = bus.o_state;
    end

    for (int a = 0; a < CH; a++) begin
      for (int b = a + 1; b < CH; b++) begin
        diff = 0;
        for (int t = 0; t < NTR; t++) if (tr_a[t][a] != tr_a[t][b]) diff++;
        checks++;
        if (diff == 0) begin
          errors++;
          $display("FAIL independence ch%0d/ch%0d got 0 differing cycles want >0", a, b);
        end
      end
    end

    // Gating: no toggles while disabled; the model checks the stretched hold.
    bus.i_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.o_toggle !== '0) begin
        errors++;
        $display("FAIL gated_toggle cycle %0d got %b want 0", i, bus.o_toggle);
      end
    end
    bus.i_en = 1'b1;
    repeat (300) tick();

    // Async reset between edges, then replay of the power-on trace.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    m_reset(BASE_SEED);
    trk_clear();
    sb_q.delete();
    bus.i_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < NTR; t++) begin
      tick();
      tr_b[t] = bus.o_state;
    end
    diff = 0;
    for (int t = 0; t < NTR; t++) if (tr_a[t] != tr_b[t]) diff++;
    checks++;
    if (diff != 0) begin
      errors++;
      $display("FAIL reset_replay got %0d differing cycles want 0", diff);
    end

    // Reseed twice with the same seed (with i_en=1 on the strobe cycle).
    for (int run = 0; run < 2; run++) begin
      bus.i_seed      = 32'h1234_5678;
      bus.i_seed_load = 1'b1;
      bus.i_en        = 1'b1;
      tick();
      bus.i_seed_load = 1'b0;
      checks++;
      if (bus.o_state !== '0 || bus.o_toggle !== '0) begin
        errors++;
        $display("FAIL reseed_wins run%0d got state=%b toggle=%b want 0/0", run, bus.o_state, bus.o_toggle);
      end
      for (int t = 0; t < NTR; t++) begin
        tick();
        if (run == 0) tr_a[t] = bus.o_state;
        else          tr_b[t] = bus.o_state;
      end
    end
    diff = 0;
    for (int t = 0; t < NTR; t++) if (tr_a[t] != tr_b[t]) diff++;
    checks++;
    if (diff != 0) begin
      errors++;
      $display("FAIL reseed_replay got %0d differing cycles want 0", diff);
    end

    // Zero seed: channel 0 falls back to seed 1 and must still toggle.
    bus.i_seed      = 32'h0;
    bus.i_seed_load = 1'b1;
    tick();
    bus.i_seed_load = 1'b0;
    tog0 = 0;
    for (int t = 0; t < 1500; t++) begin
      tick();
      if (bus.o_toggle[0]) tog0++;
    end
    checks++;
    if (tog0 == 0) begin
      errors++;
      $display("FAIL zero_seed_ch0 got %0d toggles want >0", tog0);
    end

    // Random gating and occasional reseeds, all against the model.
    for (int t = 0; t < 3000; t++) begin
      bus.i_en        = ($urandom_range(0, 3) != 0);
      bus.i_seed_load = ($urandom_range(0, 999) == 0);
      bus.i_seed      = $urandom;
      tick();
    end
    bus.i_seed_load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
